// File: rtl/apb_master_arbiter_pkg.sv
// Shared types and default parameters for the APB master arbiter.
//   tx_type_e        : transfer direction carried on req_write / pwrite
//   slave_error_e    : completion status carried on pslverr / rsp_slverr
//   apb_arb_state_e  : arbiter/sequencer state encoding
package apb_master_arbiter_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } tx_type_e;

  typedef enum logic {
    SLV_OK  = 1'b0,
    SLV_ERR = 1'b1
  } slave_error_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DECERR = 2'd3
  } apb_arb_state_e;

  localparam int DEF_NO_OF_REQUESTERS = 2;
  localparam int DEF_SLAVE_ADDR_SPAN  = 16;
  localparam int DEF_TIMEOUT_CYCLES   = 16;

endpackage

// File: rtl/apb_master_arbiter_rr.sv
// Combinational round-robin grant: the first set request at or after ptr,
// wrapping modulo NO_OF_REQUESTERS, gets a one-hot grant.
//   req : request vector
//   ptr : highest-priority requester index this cycle
//   gnt : one-hot grant (all zero when no request)
module apb_rr_arbiter #(
  parameter int NO_OF_REQUESTERS = 2,
  parameter int PTR_W            = 1
) (
  input  logic [NO_OF_REQUESTERS-1:0] req,
  input  logic [PTR_W-1:0]            ptr,
  output logic [NO_OF_REQUESTERS-1:0] gnt
);

  always_comb begin
    int   idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NO_OF_REQUESTERS; i++) begin
      idx = (int'(ptr) + i) % NO_OF_REQUESTERS;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between several requesters (round-robin),
// decodes the address to a one-hot pselx and runs SETUP/ACCESS, returning
// each completion to its owner as a one-cycle rsp_valid pulse.
//   pclk/preset          : clock, async active-high reset
//   req_*                : flattened per-requester request ports
//   rsp_*                : completion pulse (per requester) plus shared data
//   pselx..pprot, pready, prdata, pslverr : APB master bus
//
// state  | meaning
// IDLE   | no transfer; arbitrate and accept a request
// SETUP  | pselx high, penable low (one cycle)
// ACCESS | penable high, waiting for pready or timeout
// DECERR | address hit no slave; complete with error, no bus activity
module apb_master_arbiter
  import apb_master_arbiter_pkg::*;
#(
  parameter int NO_OF_REQUESTERS = DEF_NO_OF_REQUESTERS,
  parameter int NO_OF_SLAVES     = 1,
  parameter int ADDRESS_WIDTH    = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int SLAVE_ADDR_SPAN  = DEF_SLAVE_ADDR_SPAN,
  parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
  input  logic                                       pclk,
  input  logic                                       preset,
  input  logic [NO_OF_REQUESTERS-1:0]                req_valid,
  output logic [NO_OF_REQUESTERS-1:0]                req_ready,
  input  logic [NO_OF_REQUESTERS*ADDRESS_WIDTH-1:0]  req_addr,
  input  logic [NO_OF_REQUESTERS-1:0]                req_write,
  input  logic [NO_OF_REQUESTERS*DATA_WIDTH-1:0]     req_wdata,
  input  logic [NO_OF_REQUESTERS*(DATA_WIDTH/8)-1:0] req_strb,
  input  logic [NO_OF_REQUESTERS*3-1:0]              req_prot,
  output logic [NO_OF_REQUESTERS-1:0]                rsp_valid,
  output logic [DATA_WIDTH-1:0]                      rsp_rdata,
  output logic                                       rsp_slverr,
  output logic                                       rsp_timeout,
  output logic [NO_OF_SLAVES-1:0]                    pselx,
  output logic                                       penable,
  output logic                                       pwrite,
  output logic [ADDRESS_WIDTH-1:0]                   paddr,
  output logic [DATA_WIDTH-1:0]                      pwdata,
  output logic [DATA_WIDTH/8-1:0]                    pstrb,
  output logic [2:0]                                 pprot,
  input  logic                                       pready,
  input  logic [DATA_WIDTH-1:0]                      prdata,
  input  logic                                       pslverr
);

  localparam int SW    = DATA_WIDTH / 8;
  localparam int PTR_W = (NO_OF_REQUESTERS > 1) ? $clog2(NO_OF_REQUESTERS) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(NO_OF_REQUESTERS - 1);

  apb_arb_state_e               state_q, state_d;
  logic [PTR_W-1:0]             ptr_q, ptr_d;
  logic [PTR_W-1:0]             owner_q, owner_d;
  logic [CNT_W-1:0]             wait_cnt_q, wait_cnt_d;
  logic [NO_OF_SLAVES-1:0]      pselx_q, pselx_d;
  logic                         penable_q, penable_d;
  logic                         pwrite_q, pwrite_d;
  logic [ADDRESS_WIDTH-1:0]     paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]        pwdata_q, pwdata_d;
  logic [SW-1:0]                pstrb_q, pstrb_d;
  logic [2:0]                   pprot_q, pprot_d;
  logic [NO_OF_REQUESTERS-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]        rsp_rdata_q, rsp_rdata_d;
  logic                         rsp_slverr_q, rsp_slverr_d;
  logic                         rsp_timeout_q, rsp_timeout_d;

  logic [NO_OF_REQUESTERS-1:0]  gnt;
  logic [PTR_W-1:0]             win_idx;
  logic [ADDRESS_WIDTH-1:0]     win_addr;
  logic                         win_write;
  logic [DATA_WIDTH-1:0]        win_wdata;
  logic [SW-1:0]                win_strb;
  logic [2:0]                   win_prot;
  logic [ADDRESS_WIDTH-1:0]     slv_idx;
  logic                         dec_hit;
  logic [NO_OF_SLAVES-1:0]      dec_sel;

  apb_rr_arbiter #(
    .NO_OF_REQUESTERS (NO_OF_REQUESTERS),
    .PTR_W            (PTR_W)
  ) u_rr (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  assign req_ready = (state_q == IDLE) ? gnt : '0;

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NO_OF_REQUESTERS; i++) begin
      if (gnt[i]) win_idx = PTR_W'(i);
    end
  end

  assign win_addr  = req_addr[int'(win_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
  assign win_write = req_write[win_idx];
  assign win_wdata = req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign win_strb  = req_strb[int'(win_idx)*SW +: SW];
  assign win_prot  = req_prot[int'(win_idx)*3 +: 3];

  assign slv_idx = win_addr / ADDRESS_WIDTH'(SLAVE_ADDR_SPAN);
  assign dec_hit = slv_idx < ADDRESS_WIDTH'(NO_OF_SLAVES);

  always_comb begin
    dec_sel = '0;
    for (int k = 0; k < NO_OF_SLAVES; k++) begin
      dec_sel[k] = (slv_idx == ADDRESS_WIDTH'(k));
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    wait_cnt_d    = wait_cnt_q;
    pselx_d       = pselx_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    pprot_d       = pprot_q;
    rsp_valid_d   = '0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      IDLE: begin
        pselx_d   = '0;
        penable_d = 1'b0;
        if (|gnt) begin
          owner_d    = win_idx;
          ptr_d      = (win_idx == PTR_MAX) ? '0 : win_idx + PTR_W'(1);
          paddr_d    = win_addr;
          pwrite_d   = win_write;
          pwdata_d   = win_wdata;
          pstrb_d    = (win_write == WRITE) ? win_strb : '0;
          pprot_d    = win_prot;
          wait_cnt_d = '0;
          if (dec_hit) begin
            pselx_d = dec_sel;
            state_d = SETUP;
          end else begin
            state_d = DECERR;
          end
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          pselx_d              = '0;
          penable_d            = 1'b0;
          rsp_valid_d[owner_q] = 1'b1;
          rsp_rdata_d          = (pwrite_q == WRITE) ? '0 : prdata;
          rsp_slverr_d         = pslverr;
          rsp_timeout_d        = 1'b0;
          state_d              = IDLE;
        end else if (TIMEOUT_CYCLES != 0 && wait_cnt_q == CNT_LAST) begin
          pselx_d              = '0;
          penable_d            = 1'b0;
          rsp_valid_d[owner_q] = 1'b1;
          rsp_rdata_d          = '0;
          rsp_slverr_d         = SLV_ERR;
          rsp_timeout_d        = 1'b1;
          state_d              = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      DECERR: begin
        rsp_valid_d[owner_q] = 1'b1;
        rsp_rdata_d          = '0;
        rsp_slverr_d         = SLV_ERR;
        rsp_timeout_d        = 1'b0;
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      owner_q       <= '0;
      wait_cnt_q    <= '0;
      pselx_q       <= '0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      rsp_valid_q   <= '0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      wait_cnt_q    <= wait_cnt_d;
      pselx_q       <= pselx_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pprot_q       <= pprot_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign pselx       = pselx_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign pprot       = pprot_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
module tb_apb_master_arbiter;

  localparam int NR = 2;
  localparam int NS = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic              pclk = 1'b0;
  logic              preset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*AW-1:0]  req_addr;
  logic [NR-1:0]     req_write;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR*SW-1:0]  req_strb;
  logic [NR*3-1:0]   req_prot;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_slverr;
  logic              rsp_timeout;
  logic [NS-1:0]     pselx;
  logic              penable;
  logic              pwrite;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata;
  logic [SW-1:0]     pstrb;
  logic [2:0]        pprot;
  logic              pready;
  logic [DW-1:0]     prdata;
  logic              pslverr;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 pclk = ~pclk;

  apb_master_arbiter #(
    .NO_OF_REQUESTERS (NR),
    .NO_OF_SLAVES     (NS),
    .ADDRESS_WIDTH    (AW),
    .DATA_WIDTH       (DW),
    .SLAVE_ADDR_SPAN  (16),
    .TIMEOUT_CYCLES   (4)
  ) dut (
    .pclk        (pclk),
    .preset      (preset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_write   (req_write),
    .req_wdata   (req_wdata),
    .req_strb    (req_strb),
    .req_prot    (req_prot),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_slverr  (rsp_slverr),
    .rsp_timeout (rsp_timeout),
    .pselx       (pselx),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .pstrb       (pstrb),
    .pprot       (pprot),
    .pready      (pready),
    .prdata      (prdata),
    .pslverr     (pslverr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic smp();
    @(negedge pclk);
  endtask

  task automatic set_req(input int r, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb,
                         input logic [2:0] prot);
    req_valid[r]          = 1'b1;
    req_write[r]          = wr;
    req_addr[r*AW +: AW]  = addr;
    req_wdata[r*DW +: DW] = data;
    req_strb[r*SW +: SW]  = strb;
    req_prot[r*3 +: 3]    = prot;
  endtask

  logic [31:0] base [2];
  logic [31:0] wadr [2];
  logic [3:0]  wstb [2];
  int          nwr  [2];

  initial begin
    int o;
    logic [31:0] exp_data;
    preset    = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_write = '0;
    req_wdata = '0;
    req_strb  = '0;
    req_prot  = '0;
    pready    = 1'b1;
    prdata    = 32'hDEAD_BEEF;
    pslverr   = 1'b0;

    // reset values
    repeat (2) tick();
    smp();
    chk("rst_pselx",   32'(pselx), 32'h0);
    chk("rst_penable", 32'(penable), 32'h0);
    chk("rst_paddr",   paddr, 32'h0);
    chk("rst_pstrb",   32'(pstrb), 32'h0);
    chk("rst_rsp",     32'(rsp_valid), 32'h0);
    chk("rst_ready",   32'(req_ready), 32'h0);
    tick();
    preset = 1'b0;
    tick();

    // single read from requester 0
    set_req(0, 1'b0, 32'h04, 32'h0, 4'hF, 3'b010);
    smp();
    chk("rd_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    smp();
    chk("rd_setup_pselx",   32'(pselx), 32'h1);
    chk("rd_setup_penable", 32'(penable), 32'h0);
    chk("rd_setup_paddr",   paddr, 32'h04);
    chk("rd_setup_pwrite",  32'(pwrite), 32'h0);
    chk("rd_setup_pstrb",   32'(pstrb), 32'h0);
    chk("rd_setup_pprot",   32'(pprot), 32'h2);
    tick(); smp();
    chk("rd_acc_pselx",   32'(pselx), 32'h1);
    chk("rd_acc_penable", 32'(penable), 32'h1);
    tick(); smp();
    chk("rd_rsp_valid",   32'(rsp_valid), 32'h1);
    chk("rd_rsp_rdata",   rsp_rdata, 32'hDEAD_BEEF);
    chk("rd_rsp_slverr",  32'(rsp_slverr), 32'h0);
    chk("rd_rsp_timeout", 32'(rsp_timeout), 32'h0);
    chk("rd_idle_pselx",  32'(pselx), 32'h0);
    chk("rd_idle_penable", 32'(penable), 32'h0);
    tick(); smp();
    chk("rd_rsp_pulse", 32'(rsp_valid), 32'h0);

    // both requesters stream writes; pointer is 1 after requester 0 was served
    base[0] = 32'hA000_0000; wadr[0] = 32'h08; wstb[0] = 4'h5; nwr[0] = 0;
    base[1] = 32'hB000_0000; wadr[1] = 32'h14; wstb[1] = 4'hC; nwr[1] = 0;
    set_req(0, 1'b1, wadr[0], base[0], wstb[0], 3'b000);
    set_req(1, 1'b1, wadr[1], base[1], wstb[1], 3'b000);
    #1;
    for (int k = 0; k < 8; k++) begin
      o = (k + 1) % 2;
      chk("rr_grant", 32'(req_ready), 32'(1 << o));
      tick();
      exp_data = base[o] + 32'(nwr[o]);
      nwr[o]++;
      set_req(o, 1'b1, wadr[o], base[o] + 32'(nwr[o]), wstb[o], 3'b000);
      smp();
      chk("rr_pselx",  32'(pselx), (o == 0) ? 32'h1 : 32'h2);
      chk("rr_pwdata", pwdata, exp_data);
      chk("rr_pstrb",  32'(pstrb), 32'(wstb[o]));
      tick(); smp();
      chk("rr_penable", 32'(penable), 32'h1);
      tick(); smp();
      chk("rr_rsp", 32'(rsp_valid), 32'(1 << o));
    end

    // decode miss: 0x20 is beyond two 16-byte windows
    req_valid = '0;
    set_req(0, 1'b1, 32'h20, 32'h1234, 4'hF, 3'b000);
    #1;
    chk("dec_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    smp();
    chk("dec_pselx",   32'(pselx), 32'h0);
    chk("dec_penable", 32'(penable), 32'h0);
    chk("dec_norsp",   32'(rsp_valid), 32'h0);
    tick(); smp();
    chk("dec_rsp",     32'(rsp_valid), 32'h1);
    chk("dec_slverr",  32'(rsp_slverr), 32'h1);
    chk("dec_rdata",   rsp_rdata, 32'h0);
    chk("dec_timeout", 32'(rsp_timeout), 32'h0);

    // slave error on a read to slave 1
    set_req(1, 1'b0, 32'h10, 32'h0, 4'hF, 3'b000);
    pslverr = 1'b1;
    prdata  = 32'h0BAD_F00D;
    #1;
    chk("err_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    smp();
    chk("err_pselx", 32'(pselx), 32'h2);
    chk("err_pstrb", 32'(pstrb), 32'h0);
    tick(); smp();
    tick(); smp();
    chk("err_rsp",     32'(rsp_valid), 32'h2);
    chk("err_slverr",  32'(rsp_slverr), 32'h1);
    chk("err_timeout", 32'(rsp_timeout), 32'h0);
    chk("err_rdata",   rsp_rdata, 32'h0BAD_F00D);
    pslverr = 1'b0;

    // timeout: pready held low, 4 ACCESS cycles then abort
    pready = 1'b0;
    set_req(0, 1'b0, 32'h04, 32'h0, 4'hF, 3'b000);
    #1;
    chk("to_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    smp();
    chk("to_setup_pselx", 32'(pselx), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick(); smp();
      chk("to_acc_penable", 32'(penable), 32'h1);
      chk("to_acc_norsp",   32'(rsp_valid), 32'h0);
    end
    tick(); smp();
    chk("to_rsp",     32'(rsp_valid), 32'h1);
    chk("to_slverr",  32'(rsp_slverr), 32'h1);
    chk("to_timeout", 32'(rsp_timeout), 32'h1);
    chk("to_pselx",   32'(pselx), 32'h0);
    chk("to_penable", 32'(penable), 32'h0);

    // reset in the middle of ACCESS
    set_req(1, 1'b1, 32'h14, 32'h0000_CAFE, 4'h3, 3'b000);
    #1;
    chk("rst_mid_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    smp();
    tick(); smp();
    chk("rst_mid_acc", 32'(penable), 32'h1);
    #2;
    preset = 1'b1;
    #1;
    chk("rst_mid_pselx",   32'(pselx), 32'h0);
    chk("rst_mid_penable", 32'(penable), 32'h0);
    chk("rst_mid_paddr",   paddr, 32'h0);
    tick();
    preset = 1'b0;
    pready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("rst_mid_norsp", 32'(rsp_valid), 32'h0);
      tick();
    end
    set_req(0, 1'b0, 32'h00, 32'h0, 4'hF, 3'b000);
    set_req(1, 1'b0, 32'h10, 32'h0, 4'hF, 3'b000);
    smp();
    chk("rst_mid_prio", 32'(req_ready), 32'h1);
    req_valid = '0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
